// File: rtl/ps2_pkg.sv
// PS/2 receiver shared types and defaults.
// Holds the FSM state encoding, data width and default parameters.
package ps2_pkg;

    localparam int PS2_DATA_BITS = 8;

    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_FILT_LEN    = 4;
    localparam int DEF_TIMEOUT_CYC = 20000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_STOP = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Read-side bus between the PS/2 receive FIFO and its register slave.
// master: FIFO side (drives head byte, valid, flags); slave: reader (pop, clear).
interface ps2_rx_fifo_if;
    import ps2_pkg::*;

    logic [PS2_DATA_BITS-1:0] dat_o;
    logic                     valid_o;
    logic                     par_err_o;
    logic                     frm_err_o;
    logic                     ovf_o;
    logic                     rd_en_i;
    logic                     clr_i;

    modport master (
        output dat_o, valid_o, par_err_o, frm_err_o, ovf_o,
        input  rd_en_i, clr_i
    );

    modport slave (
        input  dat_o, valid_o, par_err_o, frm_err_o, ovf_o,
        output rd_en_i, clr_i
    );

endinterface

// File: rtl/ps2_rx_filt.sv
// PS/2 pad conditioning: 2-FF synchronizers, clock deglitch filter, fall pulse.
// Ports: clk_i/rst_n_i, raw ps2_clk_i/ps2_dat_i in; clk_f_o, dat_s_o, fall_o out.
module ps2_rx_filt
    import ps2_pkg::*;
#(
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_f_o,
    output logic dat_s_o,
    output logic fall_o
);

    localparam int CW = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    dat_sync_q, dat_sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_f_q, clk_f_d;
    logic          clk_f_dly_q, clk_f_dly_d;
    logic          fall_q, fall_d;

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk_i};
        dat_sync_d  = {dat_sync_q[0], ps2_dat_i};
        clk_f_d     = clk_f_q;
        cnt_d       = '0;
        // Count consecutive samples disagreeing with the filtered level.
        if (clk_sync_q[1] != clk_f_q) begin
            if (cnt_q == CNT_MAX) begin
                clk_f_d = clk_sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        clk_f_dly_d = clk_f_q;
        fall_d      = clk_f_dly_q & ~clk_f_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            cnt_q       <= '0;
            clk_f_q     <= 1'b1;
            clk_f_dly_q <= 1'b1;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            cnt_q       <= cnt_d;
            clk_f_q     <= clk_f_d;
            clk_f_dly_q <= clk_f_dly_d;
            fall_q      <= fall_d;
        end
    end

    assign clk_f_o = clk_f_q;
    assign dat_s_o = dat_sync_q[1];
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: frame decoder, timeout, sticky flags, show-ahead FIFO.
// Ports: clk_i, rst_n_i, raw ps2_clk_i/ps2_dat_i, en_i; bus (master) to register slave.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int FILT_LEN    = DEF_FILT_LEN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    input  logic en_i,
    ps2_rx_fifo_if.master bus
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int BW = $clog2(PS2_DATA_BITS);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] BIT_MAX = BW'(PS2_DATA_BITS - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef logic [PS2_DATA_BITS-1:0] byte_t;

    logic unused_clk_f;
    logic dat_s;
    logic fall;

    ps2_rx_filt #(
        .FILT_LEN (FILT_LEN)
    ) u_filt (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .ps2_clk_i (ps2_clk_i),
        .ps2_dat_i (ps2_dat_i),
        .clk_f_o   (unused_clk_f),
        .dat_s_o   (dat_s),
        .fall_o    (fall)
    );

    ps2_state_e    state_q, state_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    byte_t         shreg_q, shreg_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          par_err_q, par_err_d;
    logic          frm_err_q, frm_err_d;
    logic          ovf_q, ovf_d;
    byte_t         mem_q [FIFO_DEPTH];
    byte_t         mem_d [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic push_req, push, pop, empty, full;
    logic frm_set, par_set, ovf_set;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        par_ok_d  = par_ok_q;
        tmo_d     = tmo_q;
        push_req  = 1'b0;
        frm_set   = 1'b0;
        par_set   = 1'b0;
        if (!en_i) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
        end else if (fall) begin
            tmo_d = '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (dat_s) begin
                        frm_set = 1'b1;
                    end else begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    // Shift right from the top so the byte lands LSB-first.
                    shreg_d   = {dat_s, shreg_q[PS2_DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_MAX) begin
                        state_d = ST_PAR;
                    end
                end
                ST_PAR: begin
                    par_ok_d = ^{shreg_q, dat_s};
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!dat_s) begin
                        frm_set = 1'b1;
                    end else if (!par_ok_q) begin
                        par_set = 1'b1;
                    end else begin
                        push_req = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TMO_MAX) begin
                frm_set = 1'b1;
                state_d = ST_IDLE;
                tmo_d   = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == CNT_FULL);
        pop     = bus.rd_en_i & ~empty;
        // A simultaneous pop frees a slot, so a full FIFO still accepts.
        push    = push_req & (~full | pop);
        ovf_set = push_req & full & ~pop;
        mem_d   = mem_q;
        if (push) begin
            mem_d[wptr_q] = shreg_q;
        end
        wptr_d    = wptr_q + AW'(push);
        rptr_d    = rptr_q + AW'(pop);
        cnt_d     = cnt_q + (AW + 1)'(push) - (AW + 1)'(pop);
        // New error events win over a coincident clear.
        par_err_d = par_set | (par_err_q & ~bus.clr_i);
        frm_err_d = frm_set | (frm_err_q & ~bus.clr_i);
        ovf_d     = ovf_set | (ovf_q & ~bus.clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            par_ok_q  <= 1'b0;
            tmo_q     <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            ovf_q     <= 1'b0;
            mem_q     <= '{default: '0};
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            par_ok_q  <= par_ok_d;
            tmo_q     <= tmo_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            ovf_q     <= ovf_d;
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.dat_o     = mem_q[rptr_q];
    assign bus.valid_o   = ~empty;
    assign bus.par_err_o = par_err_q;
    assign bus.frm_err_o = frm_err_q;
    assign bus.ovf_o     = ovf_q;

endmodule
